// File: rtl/reg_file.sv
// Register file with two registered read ports and one write port.
// r0 is hard-wired to zero; reads see a same-cycle write (write-first).
module reg_file #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned REG_N  = 8,
  parameter int unsigned ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  output logic [DATA_W-1:0] a,
  output logic [DATA_W-1:0] b,
  output logic              op_valid
);

  logic [DATA_W-1:0] regs [REG_N];
  logic              wr_live;
  logic [DATA_W-1:0] rd1;
  logic [DATA_W-1:0] rd2;

  assign wr_live = we && (wa != '0);

  // A live write to the address being read forwards wd instead of stale storage.
  always_comb begin
    rd1 = regs[ra1];
    rd2 = regs[ra2];
    if (wr_live && (wa == ra1)) rd1 = wd;
    if (wr_live && (wa == ra2)) rd2 = wd;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < REG_N; i++) regs[i] <= '0;
    end else if (wr_live) begin
      regs[wa] <= wd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a        <= '0;
      b        <= '0;
      op_valid <= 1'b0;
    end else begin
      op_valid <= rd_en;
      if (rd_en) begin
        a <= rd1;
        b <= rd2;
      end
    end
  end

endmodule
